commit_unit: RTL and testbench
==============================

// Module: commit_unit
// PURPOSE
//  In-order retirement stage; consumer end of the reorder-buffer dequeue interface.
//  - Inspects the ROB head each cycle and retires ready entries by pulsing rob_rd_en.
//  - Register results go to the register file; stores are released to the LSQ by handshake.
//  - A mispredicted branch raises a flush to the front end and reservation stations.
// PARAMETERS
//  XLEN          32   datapath width of result / redirect PC
//  FLUSH_CYCLES  2    cycles flush is held high after a mispredict retires (>=1)
//  ST_TIMEOUT    255  max cycles to wait for st_ack before raising st_err
// PORTS
//  clk            in   1      clock, rising edge
//  reset_n        in   1      async active-low reset
//  head           in   ROB_entry_t  ROB head entry; uses itype, ready, value, dest_reg, branch_result, ROB_number
//  head_ready     in   1      head.ready from ROB
//  head_store     in   1      head is a store (itype 01)
//  rob_empty      in   1      ROB holds no valid entries
//  rob_rd_en      out  1      dequeue head this cycle
//  rf_we          out  1      register-file write enable
//  rf_waddr       out  5      = head.dest_reg
//  rf_wdata       out  XLEN   = head.value
//  rf_wrob        out  4      = head.ROB_number, lets rename table clear its tag on a match
//  st_req         out  1      store commit request to LSQ
//  st_rob         out  4      ROB_number of the store being released
//  st_ack         in   1      LSQ has written the store to memory
//  flush          out  1      squash all speculative state
//  redirect_pc    out  XLEN   correct PC on mispredict (head.value of the branch)
//  commit_count   out  32     retired-instruction counter
//  st_err         out  1      sticky: store-ack timeout
// BEHAVIOUR
//  Reset (async, reset_n=0): state=RUN; flush=0, st_req=0, st_err=0, commit_count=0,
//   flush counter=0, timeout counter=0. All combinational outputs are 0 while in reset.
//  itype encoding: 00 branch, 01 store, 10 ALU, 11 load.
//  branch_result: 1 = mispredicted, 0 = correct.
//  FSM states RUN, STORE, FLUSH. At most one retirement per cycle.
//  RUN: the head is retirable when !rob_empty && head_ready. A non-retirable head does nothing.
//   - itype 10/11: rf_we=1 and rob_rd_en=1, both combinational in the same cycle; stay RUN.
//   - itype 00, branch_result=0: rob_rd_en=1; stay RUN.
//   - itype 00, branch_result=1: rob_rd_en=1; latch redirect_pc<=head.value; next=FLUSH.
//   - itype 01 (head_store=1), head_ready ignored: no rd_en; next=STORE; st_req<=1; st_rob<=head.ROB_number.
//  STORE:
//   - st_req stays high until st_ack. In the ack cycle: rob_rd_en=1 (combinational), st_req<=0, next=RUN.
//   - st_ack seen in RUN or FLUSH is ignored.
//   - Timeout counter increments each STORE cycle without ack. On reaching ST_TIMEOUT: st_err<=1 (sticky until reset); keep waiting.
//  FLUSH: flush=1 for exactly FLUSH_CYCLES cycles, starting the cycle after the branch retires.
//   - No retirement, rf_we=0, rob_rd_en=0 during FLUSH; then next=RUN.
//   - ROB and RS clear on flush; the commit unit does not assume head contents during FLUSH.
//  commit_count: +1 on every cycle where rob_rd_en=1; wraps at 2^32.
//  rf_waddr, rf_wdata, rf_wrob: always driven from head; meaningful only when rf_we=1.
//  Loads with dest_reg=0: rf_we still asserts; the register file ignores x0.
//  Reset mid-STORE or mid-FLUSH: aborts immediately to RUN with all outputs at reset values.
// TESTING
//  1. Reset: reset_n=0 mid-run -> flush=0, st_req=0, commit_count=0, rob_rd_en=0 same cycle.
//  2. Three ready ALU heads (dest 5,6,7; values 0x11,0x22,0x33) on consecutive cycles
//     -> rf_we=1 for 3 cycles, matching addr/data; commit_count=3.
//  3. Head ready=0 for 4 cycles then ready -> no rd_en for 4 cycles, retire on cycle 5.
//     Also: rob_empty=1 with stale ready=1 -> no retire.
//  4. Store head ROB#9, st_ack after 3 cycles -> st_req high 3 cycles, st_rob=9,
//     rob_rd_en only in ack cycle. No ack for 256 cycles -> st_err=1, stays 1.
//  5. Mispredict branch with value 0x400 -> rob_rd_en 1 cycle, then flush=1 for 2 cycles,
//     redirect_pc=0x400; ready ALU head during flush is not retired.
//  6. Correct branch followed by load -> both retire back-to-back, flush stays 0.

Source files
------------

// File: rtl/commit_unit.sv
// In-order retirement stage: drains the ROB head into the register file, releases
// stores to the LSQ by handshake and raises a timed flush on a mispredicted branch.

package commit_unit_pkg;
    localparam int XLEN = 32;

    typedef struct packed {
        logic [1:0]      itype;
        logic            ready;
        logic [XLEN-1:0] value;
        logic [4:0]      dest_reg;
        logic            branch_result;
        logic [3:0]      ROB_number;
    } ROB_entry_t;
endpackage

// state | meaning
// RUN   | inspect ROB head, retire at most one ready entry per cycle
// STORE | store released to LSQ, waiting for st_ack (timeout sets sticky st_err)
// FLUSH | mispredict retired, flush held for FLUSH_CYCLES cycles
module commit_unit #(
    parameter int XLEN         = commit_unit_pkg::XLEN,
    parameter int FLUSH_CYCLES = 2,
    parameter int ST_TIMEOUT   = 255
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  commit_unit_pkg::ROB_entry_t  head,
    input  logic                         head_ready,
    input  logic                         head_store,
    input  logic                         rob_empty,
    output logic                         rob_rd_en,
    output logic                         rf_we,
    output logic [4:0]                   rf_waddr,
    output logic [XLEN-1:0]              rf_wdata,
    output logic [3:0]                   rf_wrob,
    output logic                         st_req,
    output logic [3:0]                   st_rob,
    input  logic                         st_ack,
    output logic                         flush,
    output logic [XLEN-1:0]              redirect_pc,
    output logic [31:0]                  commit_count,
    output logic                         st_err
);

    localparam int FW = $clog2(FLUSH_CYCLES + 1);
    localparam int TW = $clog2(ST_TIMEOUT + 1);
    localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES);
    localparam logic [TW-1:0] TMO_LOAD   = TW'(ST_TIMEOUT);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STORE = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic          rd_en_c, we_c, go_store, go_flush;
    logic [FW-1:0] flush_cnt;
    logic [TW-1:0] tmo_cnt;

    // head.ready is mirrored on head_ready; only the dedicated port is used.
    logic unused_ready;
    assign unused_ready = head.ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= RUN;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        rd_en_c  = 1'b0;
        we_c     = 1'b0;
        go_store = 1'b0;
        go_flush = 1'b0;
        case (state)
            RUN: begin
                if (!rob_empty) begin
                    if (head_store) begin
                        go_store = 1'b1;
                        state_nx = STORE;
                    end else if (head_ready) begin
                        case (head.itype)
                            2'b10, 2'b11: begin
                                rd_en_c = 1'b1;
                                we_c    = 1'b1;
                            end
                            2'b00: begin
                                rd_en_c = 1'b1;
                                if (head.branch_result) begin
                                    go_flush = 1'b1;
                                    state_nx = FLUSH;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
            STORE: begin
                if (st_ack) begin
                    rd_en_c  = 1'b1;
                    state_nx = RUN;
                end
            end
            FLUSH: begin
                if (flush_cnt <= FW'(1)) state_nx = RUN;
            end
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flush        <= 1'b0;
            st_req       <= 1'b0;
            st_err       <= 1'b0;
            st_rob       <= '0;
            redirect_pc  <= '0;
            commit_count <= '0;
            flush_cnt    <= '0;
            tmo_cnt      <= '0;
        end else begin
            if (rd_en_c) commit_count <= commit_count + 32'd1;
            case (state)
                RUN: begin
                    if (go_store) begin
                        st_req  <= 1'b1;
                        st_rob  <= head.ROB_number;
                        tmo_cnt <= TMO_LOAD;
                    end else if (go_flush) begin
                        flush       <= 1'b1;
                        flush_cnt   <= FLUSH_LOAD;
                        redirect_pc <= head.value;
                    end
                end
                STORE: begin
                    if (st_ack) begin
                        st_req <= 1'b0;
                    end else if (tmo_cnt != '0) begin
                        tmo_cnt <= tmo_cnt - TW'(1);
                        if (tmo_cnt == TW'(1)) st_err <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (flush_cnt != '0) flush_cnt <= flush_cnt - FW'(1);
                    if (flush_cnt <= FW'(1)) flush <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Combinational outputs are forced low while reset is asserted.
    assign rob_rd_en = rd_en_c & reset_n;
    assign rf_we     = we_c & reset_n;
    assign rf_waddr  = reset_n ? head.dest_reg   : '0;
    assign rf_wdata  = reset_n ? head.value      : '0;
    assign rf_wrob   = reset_n ? head.ROB_number : '0;

endmodule

// File: tb/tb_commit_unit.sv
// Directed bench for commit_unit: vector table for single-cycle retirement plus
// hand-written store, timeout, mispredict and reset sequences.

module tb_commit_unit;

    logic                         clk = 1'b0;
    logic                         reset_n;
    commit_unit_pkg::ROB_entry_t  head;
    logic                         head_ready, head_store, rob_empty;
    logic                         rob_rd_en, rf_we;
    logic [4:0]                   rf_waddr;
    logic [31:0]                  rf_wdata;
    logic [3:0]                   rf_wrob;
    logic                         st_req;
    logic [3:0]                   st_rob;
    logic                         st_ack;
    logic                         flush;
    logic [31:0]                  redirect_pc;
    logic [31:0]                  commit_count;
    logic                         st_err;

    commit_unit dut (
        .clk(clk), .reset_n(reset_n), .head(head), .head_ready(head_ready),
        .head_store(head_store), .rob_empty(rob_empty), .rob_rd_en(rob_rd_en),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wrob(rf_wrob),
        .st_req(st_req), .st_rob(st_rob), .st_ack(st_ack), .flush(flush),
        .redirect_pc(redirect_pc), .commit_count(commit_count), .st_err(st_err)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_cnt = 0;

    typedef struct {
        logic [1:0]  itype;
        logic        rdy;
        logic        empty;
        logic        br;
        logic [4:0]  dest;
        logic [31:0] val;
        logic        exp_rd;
        logic        exp_we;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] it, input logic rdy, input logic empty,
                         input logic store, input logic br, input logic [4:0] dest,
                         input logic [31:0] val, input logic [3:0] robn);
        head.itype         = it;
        head.ready         = rdy;
        head.value         = val;
        head.dest_reg      = dest;
        head.branch_result = br;
        head.ROB_number    = robn;
        head_ready         = rdy;
        head_store         = store;
        rob_empty          = empty;
    endtask

    task automatic idle();
        drive(2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 4'd0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{2'b10, 1, 0, 0, 5'd5,  32'h11, 1, 1};
        vecs[1] = '{2'b10, 1, 0, 0, 5'd6,  32'h22, 1, 1};
        vecs[2] = '{2'b10, 1, 0, 0, 5'd7,  32'h33, 1, 1};
        vecs[3] = '{2'b10, 0, 0, 0, 5'd8,  32'h44, 0, 0};
        vecs[4] = '{2'b10, 1, 1, 0, 5'd9,  32'h55, 0, 0};
        vecs[5] = '{2'b11, 1, 0, 0, 5'd0,  32'h66, 1, 1};
        vecs[6] = '{2'b00, 1, 0, 0, 5'd1,  32'h77, 1, 0};
        vecs[7] = '{2'b11, 1, 0, 0, 5'd3,  32'h88, 1, 1};
        vecs[8] = '{2'b00, 0, 0, 1, 5'd2,  32'h99, 0, 0};
        vecs[9] = '{2'b11, 1, 1, 0, 5'd4,  32'haa, 0, 0};

        // reset state, with a retirable head present
        reset_n = 1'b0;
        st_ack  = 1'b0;
        drive(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'h11, 4'd2);
        @(negedge clk); #1;
        chk("rst_rd_en", rob_rd_en, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_flush", flush, 0);
        chk("rst_st_req", st_req, 0);
        chk("rst_st_err", st_err, 0);
        chk("rst_count", commit_count, 0);
        @(negedge clk);
        reset_n = 1'b1;
        idle();

        // vector table: single-cycle behaviour in RUN
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(vecs[i].itype, vecs[i].rdy, vecs[i].empty, 1'b0, vecs[i].br,
                  vecs[i].dest, vecs[i].val, 4'(i));
            #1;
            chk($sformatf("v%0d_rd_en", i), rob_rd_en, vecs[i].exp_rd);
            chk($sformatf("v%0d_rf_we", i), rf_we, vecs[i].exp_we);
            chk($sformatf("v%0d_count", i), commit_count, exp_cnt);
            chk($sformatf("v%0d_flush", i), flush, 0);
            if (vecs[i].exp_we) begin
                chk($sformatf("v%0d_waddr", i), rf_waddr, vecs[i].dest);
                chk($sformatf("v%0d_wdata", i), rf_wdata, vecs[i].val);
                chk($sformatf("v%0d_wrob", i), rf_wrob, 4'(i));
            end
            if (vecs[i].exp_rd) exp_cnt++;
        end

        // not ready for 4 cycles, then ready
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive(2'b10, k == 4, 1'b0, 1'b0, 1'b0, 5'd12, 32'h1234, 4'd1);
            #1;
            chk($sformatf("wait%0d_rd_en", k), rob_rd_en, k == 4);
            if (k == 4) exp_cnt++;
        end

        // store ROB#9, ack on third STORE cycle
        @(negedge clk);
        drive(2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 4'd9);
        #1;
        chk("st0_rd_en", rob_rd_en, 0);
        chk("st0_req", st_req, 0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            st_ack = (k == 3);
            #1;
            chk($sformatf("st%0d_req", k), st_req, 1);
            chk($sformatf("st%0d_rob", k), st_rob, 9);
            chk($sformatf("st%0d_rd_en", k), rob_rd_en, k == 3);
            chk($sformatf("st%0d_rf_we", k), rf_we, 0);
        end
        exp_cnt++;
        @(negedge clk);
        st_ack = 1'b0;
        idle();
        #1;
        chk("st4_req", st_req, 0);
        chk("st4_count", commit_count, exp_cnt);

        // st_ack in RUN is ignored
        @(negedge clk);
        drive(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 32'h1, 4'd1);
        st_ack = 1'b1;
        #1;
        chk("ack_run_rd_en", rob_rd_en, 0);
        @(negedge clk);
        st_ack = 1'b0;
        #1;
        chk("ack_run_req", st_req, 0);
        chk("ack_run_count", commit_count, exp_cnt);

        // store timeout: st_err rises after 255 STORE cycles without ack, then sticks
        @(negedge clk);
        drive(2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 4'd4);
        for (int k = 1; k <= 260; k++) begin
            @(negedge clk);
            st_ack = (k == 260);
            #1;
            if (k == 255) chk("tmo_err_before", st_err, 0);
            if (k == 256) chk("tmo_err_set", st_err, 1);
            if (k == 259) chk("tmo_req_held", st_req, 1);
            if (k == 260) chk("tmo_ack_rd_en", rob_rd_en, 1);
        end
        exp_cnt++;
        @(negedge clk);
        st_ack = 1'b0;
        idle();
        #1;
        chk("tmo_err_sticky", st_err, 1);
        chk("tmo_req_clr", st_req, 0);

        // mispredict: retire branch, flush 2 cycles, ALU head held off during flush
        @(negedge clk);
        drive(2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'h400, 4'd3);
        #1;
        chk("mp_rd_en", rob_rd_en, 1);
        chk("mp_flush0", flush, 0);
        exp_cnt++;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            drive(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 5'd10, 32'hbeef, 4'd5);
            #1;
            chk($sformatf("mp%0d_flush", k), flush, k <= 2);
            chk($sformatf("mp%0d_rd_en", k), rob_rd_en, k == 3);
            chk($sformatf("mp%0d_rf_we", k), rf_we, k == 3);
            if (k == 1) chk("mp_redirect", redirect_pc, 32'h400);
        end
        exp_cnt++;
        @(negedge clk);
        idle();
        #1;
        chk("mp_count", commit_count, exp_cnt);

        // reset during FLUSH
        @(negedge clk);
        drive(2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'h800, 4'd3);
        @(negedge clk);
        idle();
        #1;
        chk("rf_flush_pre", flush, 1);
        reset_n = 1'b0;
        #1;
        chk("rf_flush", flush, 0);
        chk("rf_count", commit_count, 0);
        chk("rf_redirect", redirect_pc, 0);
        exp_cnt = 0;
        @(negedge clk);
        reset_n = 1'b1;

        // reset during STORE, then RUN must retire immediately
        @(negedge clk);
        drive(2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 4'd7);
        @(negedge clk);
        #1;
        chk("rs_req_pre", st_req, 1);
        reset_n = 1'b0;
        drive(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 32'h5, 4'd6);
        #1;
        chk("rs_req", st_req, 0);
        chk("rs_rd_en", rob_rd_en, 0);
        chk("rs_st_err", st_err, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rs_run_rd_en", rob_rd_en, 1);
        chk("rs_run_rf_we", rf_we, 1);
        @(negedge clk);
        idle();
        #1;
        chk("rs_count", commit_count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
